lfsr4: RTL and testbench
========================

// Module: lfsr4
// PURPOSE
//  Fibonacci linear-feedback shift register, the pseudo-random bit source of
//  the stochastic-computing datapath. Emits one pseudo-random bit per clock.
//  The state is seedable through a synchronous load so that independent streams
//  can be decorrelated. Lock-up protection keeps the register out of the all-zero state.
// PARAMETERS
//  WIDTH        4        state width in bits (>=2)
//  TAPS         4'b1100  feedback tap mask; bit i set = state[i] XORed into feedback
//  RESET_STATE  4'b0001  state after reset; must be nonzero
// PORTS (positional order: q, clk, rst, seed, load)
//  clk   in   1      single clock; all state changes on the rising edge
//  rst   in   1      reset, asynchronous, active-high
//  q     out  1      serial pseudo-random output bit = state[WIDTH-1]
//  seed  in   WIDTH  value loaded into the state when load=1
//  load  in   1      synchronous seed-load strobe
// BEHAVIOUR
//  - Reset (async, active-high): state <= RESET_STATE immediately, regardless of clk.
//    q follows state, so q=0 with the defaults. Held while rst=1; load is ignored.
//  - State update at each posedge clk, with rst=0. Priority order:
//    1. load=1: state <= seed. If seed==0, state <= RESET_STATE instead (lock-up guard).
//    2. otherwise: state <= {state[WIDTH-2:0], fb}, where fb = ^(state & TAPS).
//  - q = state[WIDTH-1], combinational from the state register only.
//    No logic between the inputs and q. q changes only on a clock edge or on reset.
//  - Latency: a loaded seed is visible on q (seed[WIDTH-1]) right after the loading edge.
//    The first shifted bit appears one edge later.
//  - Default polynomial x^4+x^3+1 is maximal length, period 15.
//    Sequence from 0001: 0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,
//    1111,1110,1100,1000, then back to 0001.
//    Resulting q stream: 0,0,0,1,0,0,1,1,0,1,0,1,1,1,1 (repeats).
//  - The all-zero state is unreachable, whether by reset, load or shift.
//  - load held high for several cycles reloads seed on every edge; the state does not advance.
//  - rst asserted mid-sequence or during load: state goes to RESET_STATE at once.
//    Shifting resumes from RESET_STATE on the first posedge after rst deasserts.
//  - X/Z on seed while load=0 has no effect on the state.
// TESTING
//  1. Reset: rst=1 for 10 ns, with clk idle -> state=0001 and q=0 before any clock edge.
//  2. Free run after reset, load=0, 30 edges -> q matches 000100110101111 twice.
//     Period is exactly 15.
//  3. Load: seed=4'b1000, load=1 for one edge -> q=1 after that edge.
//     Next state is 0001 and q goes 0,0,0,1...
//  4. Zero seed: seed=0, load=1 -> state=0001 and never 0000.
//     Run 100 cycles with no all-zero state observed.
//  5. Held load: load=1 for 5 edges with seed=4'b0110 -> q stays 0 and the state stays 0110.
//     After load drops, the next edge gives 1101.
//  6. Mid-run reset: assert rst between edges after 7 shifts -> q=0 immediately.
//     After release, the stream restarts with 0,0,0,1.

Source files
------------

// File: rtl/lfsr4.sv
// Fibonacci LFSR used as the pseudo-random bit source of the stochastic datapath.
// Seedable via a synchronous load; a zero seed is replaced by RESET_STATE so the register never locks up.
module lfsr4 #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] TAPS        = 4'b1100,
  parameter logic [WIDTH-1:0] RESET_STATE = 4'b0001
) (
  output logic             q,
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] seed,
  input  logic             load
);

  logic [WIDTH-1:0] state;
  logic             fb;

  assign fb = ^(state & TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_STATE;
    end else if (load) begin
      // An all-zero seed would freeze the shifter, so substitute the reset value.
      state <= (seed == '0) ? RESET_STATE : seed;
    end else begin
      state <= {state[WIDTH-2:0], fb};
    end
  end

  // Output is taken straight from the register so it only moves on an edge or reset.
  assign q = state[WIDTH-1];

endmodule

// File: tb/tb_lfsr4.sv
// Self-checking bench for lfsr4: directed scenarios plus randomized load/shift traffic
// checked against an arithmetic model of the polynomial x^4+x^3+1.
module tb_lfsr4;

  logic       q;
  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic [3:0] seed = 4'd0;
  logic       load = 1'b0;
  logic       clk_run = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  lfsr4 dut (
    .q    (q),
    .clk  (clk),
    .rst  (rst),
    .seed (seed),
    .load (load)
  );

  // Clock only toggles once enabled so the reset test can run with clk idle.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // Reference: next state from the rules, using integer arithmetic.
  function automatic int model_next(int s, bit ld, int sd);
    int fb;
    if (ld) return (sd == 0) ? 1 : sd;
    fb = $countones(s & 12) % 2;
    return ((s * 2) + fb) % 16;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    load = 1'b0;
    #2;
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #10;
    n_cmp++;
    if (dut.state !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_state: got %b want 0001", dut.state);
    end
    n_cmp++;
    if (q !== 1'b0) begin
      n_err++;
      $display("FAIL reset_q: got %b want 0", q);
    end
    rst = 1'b0;
    #1;
    clk_run = 1'b1;
  endtask

  task automatic test_free_run();
    logic [14:0] pat;
    logic        exp_q;
    int          first_return;
    pat = 15'b000100110101111;
    first_return = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp_q = pat[14 - (k % 15)];
      n_cmp++;
      if (q !== exp_q) begin
        n_err++;
        $display("FAIL free_run_q edge %0d: got %b want %b", k, q, exp_q);
      end
      if (dut.state == 4'b0001 && first_return == 0) first_return = k;
    end
    n_cmp++;
    if (first_return != 15) begin
      n_err++;
      $display("FAIL period: got %0d want 15", first_return);
    end
  endtask

  task automatic test_load();
    logic [3:0] exp_q;
    do_reset();
    tick();
    seed = 4'b1000;
    load = 1'b1;
    tick();
    load = 1'b0;
    n_cmp++;
    if (q !== 1'b1 || dut.state !== 4'b1000) begin
      n_err++;
      $display("FAIL load: got q=%b state=%b want q=1 state=1000", q, dut.state);
    end
    exp_q = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (q !== exp_q[3 - k]) begin
        n_err++;
        $display("FAIL load_follow edge %0d: got %b want %b", k, q, exp_q[3 - k]);
      end
    end
  endtask

  task automatic test_zero_seed();
    int  exp_s;
    bit  saw_zero;
    int  bad;
    seed = 4'b0000;
    load = 1'b1;
    tick();
    load = 1'b0;
    n_cmp++;
    if (dut.state !== 4'b0001) begin
      n_err++;
      $display("FAIL zero_seed: got %b want 0001", dut.state);
    end
    exp_s = 1;
    saw_zero = 1'b0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      exp_s = model_next(exp_s, 1'b0, 0);
      if (dut.state == 4'b0000) saw_zero = 1'b1;
      if (dut.state !== exp_s[3:0]) bad++;
    end
    n_cmp++;
    if (saw_zero) begin
      n_err++;
      $display("FAIL no_lockup: got all-zero state want never zero");
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL zero_seed_run: got %0d state errors want 0", bad);
    end
  endtask

  task automatic test_held_load();
    seed = 4'b0110;
    load = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (q !== 1'b0 || dut.state !== 4'b0110) begin
        n_err++;
        $display("FAIL held_load edge %0d: got q=%b state=%b want q=0 state=0110", k, q, dut.state);
      end
    end
    load = 1'b0;
    seed = 4'bxxxx;
    tick();
    n_cmp++;
    if (dut.state !== 4'b1101) begin
      n_err++;
      $display("FAIL held_load_release: got %b want 1101", dut.state);
    end
    seed = 4'b0000;
  endtask

  task automatic test_mid_reset();
    logic [3:0] exp_q;
    do_reset();
    for (int k = 0; k < 7; k++) tick();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (q !== 1'b0 || dut.state !== 4'b0001) begin
      n_err++;
      $display("FAIL mid_reset: got q=%b state=%b want q=0 state=0001", q, dut.state);
    end
    // Reset must dominate a load pending across an edge.
    seed = 4'b1011;
    load = 1'b1;
    tick();
    n_cmp++;
    if (dut.state !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_over_load: got %b want 0001", dut.state);
    end
    load = 1'b0;
    #2;
    rst = 1'b0;
    exp_q = 4'b0001;
    n_cmp++;
    if (q !== exp_q[3]) begin
      n_err++;
      $display("FAIL restart_q0: got %b want %b", q, exp_q[3]);
    end
    for (int k = 1; k < 4; k++) begin
      tick();
      n_cmp++;
      if (q !== exp_q[3 - k]) begin
        n_err++;
        $display("FAIL restart edge %0d: got %b want %b", k, q, exp_q[3 - k]);
      end
    end
  endtask

  task automatic test_random();
    int exp_s;
    bit ld;
    int sd;
    do_reset();
    exp_s = 1;
    for (int k = 0; k < 300; k++) begin
      ld = ($urandom_range(0, 3) == 0);
      sd = (($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 15));
      load = ld;
      seed = sd[3:0];
      tick();
      exp_s = model_next(exp_s, ld, sd);
      n_cmp++;
      if (dut.state !== exp_s[3:0] || q !== exp_s[3]) begin
        n_err++;
        $display("FAIL random cycle %0d: got state=%b q=%b want state=%b q=%b",
                 k, dut.state, q, exp_s[3:0], exp_s[3]);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_load();
    test_zero_seed();
    test_held_load();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
